radar_awg_player: RTL and testbench

Arbitrary-waveform chirp player: the responder side of the radar pulse controller's AWG handshake. Host software loads one chirp waveform into on-chip RAM over an AXI-stream port. On each `awg_init` pulse the block plays the waveform to the DAC path and reports `awg_ready`/`awg_active`/`awg_done`/`awg_data_valid` back to the pulse controller. It sits between the settings bus, the host waveform stream, and the DAC sample path, in the radar clock domain.

---
 rtl/radar_awg_player_pkg.sv | 34 +++
 rtl/awg_wfm_ram.sv | 22 ++
 rtl/radar_awg_player.sv | 150 +++++++++++++++
 tb/tb_radar_awg_player.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/radar_awg_player_pkg.sv
// Shared radar definitions: AWG state encoding, IQ layout,
// and settings-bus addresses used by the pulse controller and AWG.
package radar_awg_player_pkg;

  localparam logic [1:0] AWG_ST_EMPTY = 2'd0;
  localparam logic [1:0] AWG_ST_LOAD  = 2'd1;
  localparam logic [1:0] AWG_ST_READY = 2'd2;
  localparam logic [1:0] AWG_ST_PLAY  = 2'd3;

  typedef enum logic [1:0] {
    ST_EMPTY = AWG_ST_EMPTY,
    ST_LOAD  = AWG_ST_LOAD,
    ST_READY = AWG_ST_READY,
    ST_PLAY  = AWG_ST_PLAY
  } awg_state_e;

  localparam int IQ_I_MSB = 31;
  localparam int IQ_I_LSB = 16;
  localparam int IQ_Q_MSB = 15;
  localparam int IQ_Q_LSB = 0;

  localparam logic [7:0] SR_PULSE_PERIOD_ADDR = 8'd4;
  localparam logic [7:0] SR_PULSE_WIDTH_ADDR  = 8'd5;
  localparam logic [7:0] SR_PULSE_CTRL_ADDR   = 8'd6;
  localparam logic [7:0] SR_AWG_CLEAR_DEF     = 8'd8;

  function automatic logic [31:0] iq_pack(
    input logic [15:0] i_val,
    input logic [15:0] q_val
  );
    return {i_val, q_val};
  endfunction

endpackage

// File: rtl/awg_wfm_ram.sv
// Simple dual-port waveform RAM, one write port and one
// registered read port (1-cycle latency), BRAM-inferable.
module awg_wfm_ram #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
    rdata <= r_mem[raddr];
  end

endmodule

// File: rtl/radar_awg_player.sv
// Chirp player: loads one waveform from an AXI stream and plays
// it to the DAC path on each awg_init from the pulse controller.
module radar_awg_player
  import radar_awg_player_pkg::*;
#(
  parameter int          AWG_ADDR_W        = 12,
  parameter logic [7:0]  SR_AWG_CLEAR_ADDR = SR_AWG_CLEAR_DEF,
  parameter logic [31:0] IDLE_SAMPLE       = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [31:0] wfm_tdata,
  input  logic        wfm_tvalid,
  input  logic        wfm_tlast,
  output logic        wfm_tready,
  input  logic        awg_init,
  input  logic        awg_enable,
  output logic        awg_ready,
  output logic        awg_active,
  output logic        awg_done,
  output logic        awg_data_valid,
  output logic [31:0] dac_tdata,
  output logic        dac_tvalid,
  output logic [31:0] awg_len,
  output logic        load_overflow
);

  localparam int CW = AWG_ADDR_W + 1;
  localparam logic [CW-1:0] DEPTH = {1'b1, {AWG_ADDR_W{1'b0}}};

  awg_state_e r_state;
  awg_state_e w_next;

  logic                  r_tready;
  logic                  r_rd_valid;
  logic                  r_done;
  logic                  r_ovf;
  logic [CW-1:0]         r_wr_cnt;
  logic [CW-1:0]         r_len;
  logic [AWG_ADDR_W-1:0] r_rd_addr;

  logic                  w_clear;
  logic                  w_beat;
  logic                  w_ready;
  logic                  w_issue;
  logic                  w_last_rd;
  logic                  w_we;
  logic [AWG_ADDR_W-1:0] w_waddr;
  logic [31:0]           w_rdata;
  logic                  w_unused;

  assign w_unused  = ^set_data;
  assign w_clear   = set_stb && (set_addr == SR_AWG_CLEAR_ADDR);
  assign w_beat    = wfm_tvalid && r_tready;
  // READY is only reported once the last sample has drained out
  assign w_ready   = (r_state == ST_READY) && !r_rd_valid;
  assign w_issue   = (r_state == ST_PLAY) && awg_enable && !w_clear;
  assign w_last_rd = ({1'b0, r_rd_addr} == (r_len - CW'(1)));

  always_comb begin
    w_next  = r_state;
    w_we    = 1'b0;
    w_waddr = '0;
    unique case (r_state)
      ST_EMPTY, ST_READY: begin
        if (w_beat) begin
          w_we   = 1'b1;
          w_next = wfm_tlast ? ST_READY : ST_LOAD;
        end else if (w_ready && awg_init && awg_enable) begin
          w_next = ST_PLAY;
        end
      end
      ST_LOAD: begin
        if (w_beat) begin
          w_we    = (r_wr_cnt != DEPTH);
          w_waddr = r_wr_cnt[AWG_ADDR_W-1:0];
          if (wfm_tlast) w_next = ST_READY;
        end
      end
      ST_PLAY: begin
        if (!awg_enable || w_last_rd) w_next = ST_READY;
      end
    endcase
    if (w_clear) begin
      w_next = ST_EMPTY;
      w_we   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_tready   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_wr_cnt   <= '0;
      r_len      <= '0;
      r_rd_addr  <= '0;
    end else begin
      r_state    <= w_next;
      r_tready   <= (w_next != ST_PLAY);
      r_rd_valid <= w_issue;
      r_done     <= w_issue && w_last_rd;
      if (w_next == ST_PLAY && r_state != ST_PLAY)
        r_rd_addr <= '0;
      else if (w_issue)
        r_rd_addr <= r_rd_addr + AWG_ADDR_W'(1);
      if (w_clear) begin
        r_len <= '0;
      end else if (w_beat && r_state == ST_LOAD) begin
        // counter parks at DEPTH; extra beats only flag overflow
        if (r_wr_cnt == DEPTH) r_ovf <= 1'b1;
        else r_wr_cnt <= r_wr_cnt + CW'(1);
        if (wfm_tlast)
          r_len <= (r_wr_cnt == DEPTH) ? DEPTH : r_wr_cnt + CW'(1);
      end else if (w_beat) begin
        r_ovf    <= 1'b0;
        r_wr_cnt <= CW'(1);
        r_len    <= wfm_tlast ? CW'(1) : '0;
      end
    end
  end

  awg_wfm_ram #(
    .ADDR_W (AWG_ADDR_W),
    .DATA_W (32)
  ) u_ram (
    .clk   (clk),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (wfm_tdata),
    .raddr (r_rd_addr),
    .rdata (w_rdata)
  );

  assign wfm_tready     = r_tready;
  assign awg_ready      = w_ready;
  assign awg_active     = (r_state == ST_PLAY) || r_rd_valid;
  assign awg_done       = r_done;
  assign awg_data_valid = r_rd_valid;
  assign dac_tvalid     = r_rd_valid;
  assign dac_tdata      = r_rd_valid ? w_rdata : IDLE_SAMPLE;
  assign awg_len        = {{(32-CW){1'b0}}, r_len};
  assign load_overflow  = r_ovf;

endmodule

// File: tb/tb_radar_awg_player.sv
// Randomized bench for radar_awg_player against a sample-queue
// model of load length, overflow and per-cycle play output.
module tb_radar_awg_player;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [31:0] wfm_tdata;
  logic        wfm_tvalid;
  logic        wfm_tlast;
  logic        wfm_tready;
  logic        awg_init;
  logic        awg_enable;
  logic        awg_ready;
  logic        awg_active;
  logic        awg_done;
  logic        awg_data_valid;
  logic [31:0] dac_tdata;
  logic        dac_tvalid;
  logic [31:0] awg_len;
  logic        load_overflow;

  always #5 clk = ~clk;

  radar_awg_player #(
    .AWG_ADDR_W        (AW),
    .SR_AWG_CLEAR_ADDR (8'd8),
    .IDLE_SAMPLE       (32'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .set_stb        (set_stb),
    .set_addr       (set_addr),
    .set_data       (set_data),
    .wfm_tdata      (wfm_tdata),
    .wfm_tvalid     (wfm_tvalid),
    .wfm_tlast      (wfm_tlast),
    .wfm_tready     (wfm_tready),
    .awg_init       (awg_init),
    .awg_enable     (awg_enable),
    .awg_ready      (awg_ready),
    .awg_active     (awg_active),
    .awg_done       (awg_done),
    .awg_data_valid (awg_data_valid),
    .dac_tdata      (dac_tdata),
    .dac_tvalid     (dac_tvalid),
    .awg_len        (awg_len),
    .load_overflow  (load_overflow)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] m_mem [$];
  int          m_len = 0;
  bit          m_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_tready"}, wfm_tready, 0);
    check({tag, "_ready"}, awg_ready, 0);
    check({tag, "_active"}, awg_active, 0);
    check({tag, "_done"}, awg_done, 0);
    check({tag, "_tvalid"}, dac_tvalid, 0);
    check({tag, "_tdata"}, dac_tdata, 32'h0);
    check({tag, "_len"}, awg_len, 0);
    check({tag, "_ovf"}, load_overflow, 0);
  endtask

  task automatic load(input int n, input bit ramp, input int init_beat);
    logic [31:0] d;
    m_mem.delete();
    for (int i = 0; i < n; i++) begin
      if (i > 0 && $urandom_range(0, 3) == 0) begin
        wfm_tvalid = 1'b0;
        tick();
      end
      d = ramp ? {16'(i + 1), 16'(i + 1)} : $urandom();
      if (i < DEPTH) m_mem.push_back(d);
      wfm_tdata  = d;
      wfm_tvalid = 1'b1;
      wfm_tlast  = (i == n - 1);
      awg_init   = (i == init_beat);
      awg_enable = 1'b1;
      tick();
      awg_init   = 1'b0;
      wfm_tvalid = 1'b0;
      wfm_tlast  = 1'b0;
      check("ld_active", awg_active, 0);
      check("ld_ready", awg_ready, 32'(i == n - 1));
    end
    m_len = (n < DEPTH) ? n : DEPTH;
    m_ovf = (n > DEPTH);
    check("ld_len", awg_len, m_len);
    check("ld_ovf", load_overflow, 32'(m_ovf));
  endtask

  // kind: 0 full play, 1 enable drop, 2 clear; a = cycles into PLAY
  task automatic play(input int kind, input int a);
    int nv;
    bit vexp;
    nv = (kind == 0 || a > m_len) ? m_len : a;
    awg_init   = 1'b1;
    awg_enable = 1'b1;
    tick();
    awg_init = 1'b0;
    for (int t = 1; t <= nv + 2; t++) begin
      vexp = (t >= 2) && (t - 2 < nv);
      check("dac_tvalid", dac_tvalid, 32'(vexp));
      check("data_valid", awg_data_valid, 32'(vexp));
      check("dac_tdata", dac_tdata, vexp ? m_mem[t-2] : 32'h0);
      check("awg_done", awg_done, 32'(vexp && (t - 2 == m_len - 1)));
      check("awg_active", awg_active, 32'(t <= nv + 1));
      check("awg_ready", awg_ready, 32'(kind != 2 && t >= nv + 2));
      if (kind == 1 && t == a + 1) awg_enable = 1'b0;
      if (kind == 2 && t == a + 1) begin
        set_stb  = 1'b1;
        set_addr = 8'd8;
        set_data = $urandom();
      end
      if (t < nv + 2) begin
        tick();
        awg_enable = 1'b1;
        set_stb    = 1'b0;
      end
    end
    awg_enable = 1'b1;
    if (kind == 2) m_len = 0;
    check("play_len", awg_len, m_len);
  endtask

  task automatic dead_init(input string tag);
    awg_init   = 1'b1;
    awg_enable = 1'b1;
    tick();
    awg_init = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check({tag, "_active"}, awg_active, 0);
      check({tag, "_tvalid"}, dac_tvalid, 0);
      check({tag, "_ready"}, awg_ready, 0);
      check({tag, "_len"}, awg_len, 0);
      tick();
    end
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    set_stb    = 1'b0;
    set_addr   = '0;
    set_data   = '0;
    wfm_tdata  = '0;
    wfm_tvalid = 1'b0;
    wfm_tlast  = 1'b0;
    awg_init   = 1'b0;
    awg_enable = 1'b0;
    repeat (3) tick();
    chk_reset_vals("rst");
    reset = 1'b0;
    tick();
    check("rst_tready_after", wfm_tready, 1);
    check("rst_ready_after", awg_ready, 0);

    dead_init("empty_init");

    load(4, 1'b1, -1);
    play(0, 0);
    load(1, 1'b0, -1);
    play(0, 0);
    load(20, 1'b0, -1);
    play(0, 0);
    load(16, 1'b0, 2);
    play(1, 3);
    play(0, 0);

    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 22);
      load(n, 1'b0, (n > 2) ? 1 : -1);
      if ($urandom_range(0, 1) == 1 && m_len > 1)
        play(1, $urandom_range(0, m_len - 1));
      else
        play(0, 0);
      play(0, 0);
    end

    load(6, 1'b0, -1);
    play(2, 2);
    dead_init("clr_play");

    load(5, 1'b0, -1);
    set_stb  = 1'b1;
    set_addr = 8'd3;
    set_data = $urandom();
    tick();
    set_stb = 1'b0;
    check("other_addr_len", awg_len, 5);
    check("other_addr_ready", awg_ready, 1);
    set_stb    = 1'b1;
    set_addr   = 8'd8;
    awg_init   = 1'b1;
    awg_enable = 1'b1;
    tick();
    set_stb  = 1'b0;
    awg_init = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("clr_init_active", awg_active, 0);
      check("clr_init_tvalid", dac_tvalid, 0);
      check("clr_init_ready", awg_ready, 0);
      check("clr_init_len", awg_len, 0);
      tick();
    end

    load(8, 1'b0, -1);
    awg_init   = 1'b1;
    awg_enable = 1'b1;
    tick();
    awg_init = 1'b0;
    tick();
    tick();
    check("mid_tvalid", dac_tvalid, 1);
    check("mid_tdata", dac_tdata, m_mem[1]);
    reset = 1'b1;
    tick();
    chk_reset_vals("mid_rst");
    reset = 1'b0;
    tick();
    check("mid_rst_tready", wfm_tready, 1);
    check("mid_rst_active", awg_active, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
